// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// InterruptController
//
// Purpose: collects NUM_SRC asynchronous interrupt lines, synchronises and
// edge-detects them, latches events as pending, applies per-source and global
// masking, and raises a single locked request (with its vector address) to
// the pipeline hazard control unit. The dispatch is recognised by watching the
// hazard unit's state output; further requests are held off until the handler
// signals return (no nesting).
//
// Ports:
//   clock_i                      system clock, all logic on posedge
//   reset_i                      synchronous active-high reset
//   irq_src_i                    asynchronous level sources, rising edge = event
//   mask_we_i / mask_wdata_i     mask register write strobe / data (1 = enabled)
//   gie_we_i / gie_wdata_i       global enable write strobe / data
//   pend_clr_i                   one-cycle per-bit software clear of pending
//   hcu_state_i                  hazard control unit state (4'h2 = Interrupt)
//   return_i                     handler-return pulse shared with the hazard unit
//   interrupt_o                  registered request to the hazard unit
//   interrupt_vector_address_o   vector of the requested source (0 outside REQ)
//   pending_o                    pending register
//   mask_o                       mask register
//   gie_o                        global interrupt enable
//   in_service_o                 handler currently running
//   active_id_o                  index of the requested or in-service source
// ---------------------------------------------------------------------------
module interrupt_controller #(
  parameter int          NUM_SRC       = 8,
  parameter int          ID_W          = 3,
  parameter logic [13:0] VECTOR_BASE   = 14'h0100,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               gie_we_i,
  input  logic               gie_wdata_i,
  input  logic [NUM_SRC-1:0] pend_clr_i,
  input  logic [3:0]         hcu_state_i,
  input  logic               return_i,
  output logic               interrupt_o,
  output logic [13:0]        interrupt_vector_address_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] mask_o,
  output logic               gie_o,
  output logic               in_service_o,
  output logic [ID_W-1:0]    active_id_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [3:0] HCU_INTERRUPT = 4'h2;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               gie_q, gie_d;
  logic [1:0]         state_q, state_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [13:0]        vector_q, vector_d;

  logic [NUM_SRC-1:0] rise_w;
  logic [NUM_SRC-1:0] eligible_w;
  logic [NUM_SRC-1:0] dispatch_clr_w;
  logic               dispatch_w;
  logic               win_valid_w;
  logic [ID_W-1:0]    win_id_w;

  // Input path: two flops for metastability, a third remembering the previous
  // synchronised level so that only a 0->1 transition counts as an event.
  // Pending, mask and global enable are plain registers with their own update
  // rules computed below.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
    end else begin
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
    end
  end

  // Pending bookkeeping. A fresh edge is OR-ed in after the clear so a new
  // event arriving in the same cycle as a software or dispatch clear is kept.
  always_comb begin
    rise_w         = sync2_q & ~sync3_q;
    dispatch_w     = (state_q == ST_REQ) && (hcu_state_i == HCU_INTERRUPT);
    dispatch_clr_w = dispatch_w ? (NUM_SRC'(1) << active_id_q) : '0;
    pending_d      = (pending_q & ~(pend_clr_i | dispatch_clr_w)) | rise_w;
    mask_d         = mask_we_i ? mask_wdata_i : mask_q;
    gie_d          = gie_we_i ? gie_wdata_i : gie_q;
  end

  // Fixed-priority arbitration over enabled pending sources: scanning from the
  // top down leaves the lowest set index as the winner.
  always_comb begin
    eligible_w  = gie_q ? (pending_q & mask_q) : '0;
    win_valid_w = |eligible_w;
    win_id_w    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_w[i]) begin
        win_id_w = ID_W'(i);
      end
    end
  end

  // Request FSM. The winner and its vector are captured on entry to REQ and
  // then frozen, so nothing that changes while the hazard unit is deciding can
  // move the request. Leaving REQ only happens on the hazard unit entering its
  // Interrupt state; leaving SERVICE only happens on the handler return.
  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    in_service_d = in_service_q;
    active_id_d  = active_id_q;
    vector_d     = vector_q;
    case (state_q)
      ST_IDLE: begin
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        vector_d     = '0;
        if (win_valid_w) begin
          active_id_d = win_id_w;
          vector_d    = VECTOR_BASE + 14'(win_id_w) * 14'(VECTOR_STRIDE);
          interrupt_d = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dispatch_w) begin
          interrupt_d  = 1'b0;
          vector_d     = '0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (return_i) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        vector_d     = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // FSM and registered outputs. Keeping interrupt and the vector in their own
  // flops means they are glitch-free and stable across the negedge on which
  // the hazard unit updates its state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
      vector_q     <= '0;
    end else begin
      state_q      <= state_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
    end
  end

  assign interrupt_o                = interrupt_q;
  assign interrupt_vector_address_o = vector_q;
  assign pending_o                  = pending_q;
  assign mask_o                     = mask_q;
  assign gie_o                      = gie_q;
  assign in_service_o               = in_service_q;
  assign active_id_o                = active_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Purpose: self-checking bench for interrupt_controller. The bench plays the
// role of the hazard control unit (drives hcuState on negedge, pulses return).
// Every time stimulus creates an event that must eventually be requested, the
// expected source id and vector are pushed into a scoreboard queue; a separate
// monitor pops an entry on each rising edge of interrupt and compares it.
// Directed scenarios are followed by randomised rounds whose expectations come
// from a set-level model: requests are the raised & enabled sources in
// ascending order, leftovers are the raised sources that were not enabled.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irqSrc;
  logic        maskWe;
  logic [7:0]  maskWdata;
  logic        gieWe;
  logic        gieWdata;
  logic [7:0]  pendClr;
  logic [3:0]  hcuState;
  logic        returnPulse;
  logic        interrupt;
  logic [13:0] vectorAddr;
  logic [7:0]  pending;
  logic [7:0]  mask;
  logic        gie;
  logic        inService;
  logic [2:0]  activeId;

  int testsRun    = 0;
  int testsFailed = 0;
  int lastExpId   = 0;

  typedef struct {
    int id;
    int vec;
  } expT;

  expT expQ[$];

  interrupt_controller #(
    .NUM_SRC(8),
    .ID_W(3),
    .VECTOR_BASE(14'h0100),
    .VECTOR_STRIDE(4)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .irq_src_i(irqSrc),
    .mask_we_i(maskWe),
    .mask_wdata_i(maskWdata),
    .gie_we_i(gieWe),
    .gie_wdata_i(gieWdata),
    .pend_clr_i(pendClr),
    .hcu_state_i(hcuState),
    .return_i(returnPulse),
    .interrupt_o(interrupt),
    .interrupt_vector_address_o(vectorAddr),
    .pending_o(pending),
    .mask_o(mask),
    .gie_o(gie),
    .in_service_o(inService),
    .active_id_o(activeId)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Advance one full cycle: inputs driven and outputs sampled at negedge.
  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Vector address derived from the source index by plain arithmetic.
  function automatic int expVector(input int id);
    return (256 + id * 4) % 16384;
  endfunction

  function automatic logic [3:0] randomNonInterrupt();
    int v;
    v = $urandom_range(0, 15);
    if (v == 2) v = 0;
    return 4'(v);
  endfunction

  task automatic pushExpected(input int id);
    expT e;
    e.id  = id;
    e.vec = expVector(id);
    expQ.push_back(e);
  endtask

  // Write mask and global enable in one cycle.
  task automatic applyStimulus(input logic [7:0] maskVal, input logic gieVal);
    maskWe    = 1'b1;
    maskWdata = maskVal;
    gieWe     = 1'b1;
    gieWdata  = gieVal;
    stepCycle();
    maskWe    = 1'b0;
    gieWe     = 1'b0;
  endtask

  // Behave as the hazard unit for one request: wait for it, dispatch after a
  // random delay, optionally re-pulse some sources while in service, return.
  task automatic serviceOne(input logic [7:0] retrigger);
    int waited;
    waited = 0;
    while (!interrupt && waited < 30) begin
      hcuState = randomNonInterrupt();
      stepCycle();
      waited++;
    end
    checkOutput("request_seen", 32'(interrupt), 32'd1);
    if (!interrupt) return;
    repeat ($urandom_range(0, 3)) begin
      hcuState = randomNonInterrupt();
      stepCycle();
      checkOutput("request_held", 32'(interrupt), 32'd1);
    end
    hcuState = 4'h2;
    stepCycle();
    hcuState = randomNonInterrupt();
    checkOutput("dispatch_interrupt", 32'(interrupt), 32'd0);
    checkOutput("dispatch_in_service", 32'(inService), 32'd1);
    checkOutput("dispatch_vector", 32'(vectorAddr), 32'd0);
    checkOutput("dispatch_pending_clear", 32'(pending[lastExpId]), 32'd0);
    if (retrigger != 8'h00) begin
      irqSrc = irqSrc | retrigger;
      stepCycle();
      irqSrc = irqSrc & ~retrigger;
      repeat (4) stepCycle();
      checkOutput("retrigger_pending", 32'(pending & retrigger), 32'(retrigger));
      checkOutput("no_nested_request", 32'(interrupt), 32'd0);
    end else begin
      repeat ($urandom_range(0, 3)) stepCycle();
    end
    checkOutput("service_in_service", 32'(inService), 32'd1);
    returnPulse = 1'b1;
    stepCycle();
    returnPulse = 1'b0;
    checkOutput("return_in_service", 32'(inService), 32'd0);
    checkOutput("return_interrupt", 32'(interrupt), 32'd0);
  endtask

  // Scoreboard monitor: each new request must match the oldest expectation.
  initial begin
    logic prevInt;
    expT  e;
    prevInt = 1'b0;
    forever begin
      @(negedge clock);
      if (interrupt && !prevInt) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_request: got id %0d vector %0h, expected no request", activeId, vectorAddr);
        end else begin
          e = expQ.pop_front();
          lastExpId = e.id;
          checkOutput("request_id", 32'(activeId), 32'(e.id));
          checkOutput("request_vector", 32'(vectorAddr), 32'(e.vec));
        end
      end
      prevInt = interrupt;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence: directed scenarios, then randomised rounds.
  initial begin
    logic [7:0] maskVal;
    logic       gieVal;
    logic [7:0] raised;
    logic [7:0] leftover;
    int         nExp;
    int         waited;

    reset       = 1'b1;
    irqSrc      = '0;
    maskWe      = 1'b0;
    maskWdata   = '0;
    gieWe       = 1'b0;
    gieWdata    = 1'b0;
    pendClr     = '0;
    hcuState    = 4'h0;
    returnPulse = 1'b0;

    @(negedge clock);
    repeat (3) stepCycle();
    checkOutput("reset_interrupt", 32'(interrupt), 32'd0);
    checkOutput("reset_vector", 32'(vectorAddr), 32'd0);
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_mask", 32'(mask), 32'd0);
    checkOutput("reset_gie", 32'(gie), 32'd0);
    checkOutput("reset_in_service", 32'(inService), 32'd0);
    checkOutput("reset_active_id", 32'(activeId), 32'd0);
    reset = 1'b0;

    applyStimulus(8'hFF, 1'b1);
    checkOutput("mask_write", 32'(mask), 32'hFF);
    checkOutput("gie_write", 32'(gie), 32'd1);

    // Single source: pending two cycles after the edge, request one after that.
    pushExpected(3);
    irqSrc = 8'h08;
    stepCycle();
    checkOutput("latency_k_pending", 32'(pending), 32'd0);
    stepCycle();
    checkOutput("latency_k1_pending", 32'(pending), 32'd0);
    stepCycle();
    checkOutput("latency_k2_pending", 32'(pending), 32'h08);
    checkOutput("latency_k2_interrupt", 32'(interrupt), 32'd0);
    stepCycle();
    checkOutput("latency_k3_interrupt", 32'(interrupt), 32'd1);
    checkOutput("latency_k3_vector", 32'(vectorAddr), 32'h010C);
    serviceOne(8'h00);
    irqSrc = 8'h00;

    // Two simultaneous sources: lower index served first.
    pushExpected(1);
    pushExpected(5);
    irqSrc = 8'h22;
    serviceOne(8'h00);
    serviceOne(8'h00);
    irqSrc = 8'h00;

    // Masked source stays pending until the mask enables it.
    applyStimulus(8'h00, 1'b1);
    irqSrc = 8'h04;
    stepCycle();
    irqSrc = 8'h00;
    repeat (5) stepCycle();
    checkOutput("masked_pending", 32'(pending), 32'h04);
    checkOutput("masked_interrupt", 32'(interrupt), 32'd0);
    pushExpected(2);
    maskWe    = 1'b1;
    maskWdata = 8'h04;
    stepCycle();
    maskWe    = 1'b0;
    checkOutput("unmask_write_cycle", 32'(interrupt), 32'd0);
    stepCycle();
    checkOutput("unmask_next_cycle", 32'(interrupt), 32'd1);
    serviceOne(8'h00);
    applyStimulus(8'hFF, 1'b1);

    // Re-trigger of the in-service source waits for return.
    pushExpected(0);
    pushExpected(0);
    irqSrc = 8'h01;
    stepCycle();
    irqSrc = 8'h00;
    serviceOne(8'h01);
    serviceOne(8'h00);

    // Reset in the middle of a request discards everything.
    pushExpected(1);
    irqSrc = 8'h22;
    waited = 0;
    while (!interrupt && waited < 20) begin
      stepCycle();
      waited++;
    end
    checkOutput("abort_request_seen", 32'(interrupt), 32'd1);
    checkOutput("abort_pending_before", 32'(pending), 32'h22);
    reset  = 1'b1;
    irqSrc = 8'h00;
    stepCycle();
    checkOutput("abort_interrupt", 32'(interrupt), 32'd0);
    checkOutput("abort_pending", 32'(pending), 32'd0);
    checkOutput("abort_in_service", 32'(inService), 32'd0);
    checkOutput("abort_vector", 32'(vectorAddr), 32'd0);
    checkOutput("abort_active_id", 32'(activeId), 32'd0);
    checkOutput("abort_mask", 32'(mask), 32'd0);
    checkOutput("abort_gie", 32'(gie), 32'd0);
    repeat (3) stepCycle();
    reset = 1'b0;
    applyStimulus(8'hFF, 1'b1);
    repeat (8) stepCycle();
    checkOutput("post_abort_pending", 32'(pending), 32'd0);
    checkOutput("post_abort_interrupt", 32'(interrupt), 32'd0);

    // Randomised rounds checked against the set-level model.
    for (int round = 0; round < 24; round++) begin
      maskVal = 8'($urandom_range(0, 255));
      gieVal  = ($urandom_range(0, 4) != 0);
      raised  = 8'($urandom_range(1, 255));
      applyStimulus(maskVal, gieVal);
      nExp = 0;
      for (int i = 0; i < 8; i++) begin
        if (raised[i] && maskVal[i] && gieVal) begin
          pushExpected(i);
          nExp++;
        end
      end
      leftover = raised & ~(gieVal ? maskVal : 8'h00);
      irqSrc = raised;
      for (int n = 0; n < nExp; n++) begin
        serviceOne(8'h00);
      end
      repeat (6) stepCycle();
      checkOutput("random_leftover_pending", 32'(pending), 32'(leftover));
      checkOutput("random_idle_interrupt", 32'(interrupt), 32'd0);
      irqSrc  = 8'h00;
      pendClr = 8'hFF;
      stepCycle();
      pendClr = 8'h00;
      checkOutput("random_pend_clr", 32'(pending), 32'd0);
      repeat (2) stepCycle();
    end

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream feeder of the pipeline hazard control unit. Collects N external interrupt sources, synchronises and edge-detects them, and latches them as pending.
- Applies per-source and global masking, then selects the highest-priority source. Drives `interrupt` and `interrupt_vector_address[13:0]` into the hazard control unit.
- Detects dispatch by watching the hazard unit's `state` output. Holds off further requests until the handler returns; no nesting.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..16)
- ID_W, 3, width of source index (clog2 of NUM_SRC)
- VECTOR_BASE, 14'h0100, vector address of source 0
- VECTOR_STRIDE, 4, address spacing between consecutive source vectors

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- irq_src  in  NUM_SRC  asynchronous level sources; rising edge = event
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_SRC  new mask value (1 = enabled)
- gie_we  in  1  write strobe for global enable
- gie_wdata  in  1  new global enable value
- pend_clr  in  NUM_SRC  one-cycle per-bit software clear of pending
- hcu_state  in  4  state output of hazard control unit (4'h2 = Interrupt)
- return  in  1  same return pulse presented to hazard control unit
- interrupt  out  1  request to hazard control unit
- interrupt_vector_address  out  14  vector of requested source
- pending  out  NUM_SRC  pending register
- mask  out  NUM_SRC  mask register
- gie  out  1  global interrupt enable
- in_service  out  1  handler currently running
- active_id  out  ID_W  index of requested or in-service source

Behaviour:
- Reset: all outputs 0; sync/edge flops 0; FSM = IDLE. Reset mid-REQ or mid-SERVICE aborts to IDLE and discards all pending bits.
- Input path: 2-flop synchroniser per source, plus a third flop holding the previous synchronised value. edge[i] = s2[i] & ~s3[i].
- Latency: irq_src rising before posedge k → pending[i] set at posedge k+2 → interrupt high after posedge k+3, provided the FSM is IDLE and the source is enabled.
- Pending update per bit: next = (pending & ~clr) | edge, where clr = pend_clr OR dispatch-clear for active_id.
  - An edge in the same cycle as a clear wins: the bit stays set, because it is a new event.
  - A level held high does not re-trigger.
- mask / gie: update on the posedge where their write strobe is high. Mask writes never alter pending.
- Eligible set: pending & mask, gated by gie. Priority: lowest index wins.
- FSM IDLE:
  - interrupt=0, in_service=0.
  - If the eligible set is non-empty: latch its winner into active_id; go to REQ.
- FSM REQ:
  - interrupt=1.
  - interrupt_vector_address = (VECTOR_BASE + active_id*VECTOR_STRIDE) mod 2^14, registered and stable for the whole REQ.
  - The request is locked: later mask/gie/pend_clr changes or higher-priority arrivals do not change active_id or drop interrupt.
  - When hcu_state==4'h2 is sampled: clear pending[active_id]; interrupt→0; in_service→1; go to SERVICE.
  - return in REQ is ignored.
- FSM SERVICE:
  - interrupt=0, in_service=1, active_id held.
  - On return==1: in_service→0; go to IDLE.
  - A new arbitration may start on the next cycle (earliest re-request: 2 posedges after return).
- interrupt_vector_address is 0 outside REQ.
- Unused encodings of FSM state go to IDLE.
- Timing with the hazard unit: hcu_state changes on negedge and is sampled here on posedge. interrupt is a registered output and is stable across the negedge.

Test Plan:
- Reset, gie=1, mask=8'hFF; pulse irq_src[3] → pending=8'h08 at k+2; interrupt=1, active_id=3, vector=14'h010C at k+3.
- REQ on source 3; drive hcu_state=4'h2 → next posedge: interrupt=0, pending[3]=0, in_service=1. Pulse return → in_service=0, FSM IDLE.
- Raise irq_src[5] and irq_src[1] together → active_id=1, vector=14'h0104. After dispatch and return, active_id=5, vector=14'h0114.
- mask=8'h00, pulse irq_src[2] → pending=8'h04, interrupt stays 0. Write mask=8'h04 → interrupt=1 on the posedge after the write.
- During SERVICE of source 0, pulse irq_src[0] again → pending[0] re-set, no request until return. After return, interrupt re-asserts with vector 14'h0100.
- Assert reset while in REQ with pending=8'h22 → next posedge all outputs 0, FSM IDLE. After release, no request occurs without new edges.
